// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter
// Brief    : VGA 800x525 raster timing plus frame-buffer arbitration between
//            display scan-out and a single writer. The writer is granted the
//            buffer only inside blanking, and is pre-empted GUARD pixel ticks
//            before active video resumes.
// Options  : VGA_ARB_STATS_EN adds a saturating 16-bit abort counter output.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
  parameter int DIV   = 4,  // system clocks per pixel tick (>= 2)
  parameter int GUARD = 8   // pixel ticks of pre-emption before active video
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count,
  output logic        pix_tick,
  output logic        frame_start,
  output logic        disp_own,
  input  logic        wr_req,
  input  logic        wr_done,
  output logic        wr_grant,
  output logic        wr_abort
`ifdef VGA_ARB_STATS_EN
  ,
  output logic [15:0] abort_cnt
`endif
);

  // Divider width and terminal value
  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  // Raster geometry
  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_PRE    = 10'd479;  // last visible line
  localparam logic [9:0] CLOSE_H  = 10'(800 - GUARD);

  // Arbiter states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_COOL  = 2'd2;

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             abort_q;
  logic             abort_set;
  logic             line_end;
  logic             blank;
  logic             closing;
  logic             win;

  assign pix_tick    = en && (div_cnt == DIV_LAST);
  assign line_end    = (h_count == H_LAST);
  assign frame_start = pix_tick && line_end && (v_count == V_LAST);
  assign disp_own    = (h_count < H_ACTIVE) && (v_count < V_ACTIVE);

  // Pixel-clock divider: free-runs 0..DIV-1 while enabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  // Raster counters advance once per pixel tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pix_tick) begin
      if (line_end) begin
        h_count <= '0;
        v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
      end else begin
        h_count <= h_count + 10'd1;
      end
    end
  end

  // Write window: blanking, minus the guard stretch that leads into a visible
  // pixel (end of lines 0..478 and end of line 524); line 479's blanking runs
  // straight into vertical blank, so it stays open.
  always_comb begin
    blank   = (h_count >= H_ACTIVE) || (v_count >= V_ACTIVE);
    closing = (h_count >= CLOSE_H) && ((v_count < V_PRE) || (v_count == V_LAST));
    win     = blank && !closing;
  end

  // Arbiter state register; everything holds while en is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      abort_q <= 1'b0;
    end else begin
      if (en) begin
        state <= state_next;
      end
      abort_q <= abort_set;
    end
  end

  // Arbiter next state; wr_done takes precedence over window close
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (wr_req && win)   state_next = ST_GRANT;
      ST_GRANT: if (wr_done || !win) state_next = ST_COOL;
      ST_COOL:                       state_next = ST_IDLE;
      default:                       state_next = ST_IDLE;
    endcase
  end

  // Arbiter outputs: grant is the registered GRANT state, abort a one-shot
  always_comb begin
    wr_grant  = (state == ST_GRANT);
    abort_set = en && (state == ST_GRANT) && !wr_done && !win;
    wr_abort  = abort_q && en;
  end

`ifdef VGA_ARB_STATS_EN
  // Saturating count of pre-emptions, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      abort_cnt <= '0;
    end else if (wr_abort && (abort_cnt != 16'hFFFF)) begin
      abort_cnt <= abort_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_arbiter
// Brief    : Self-checking bench for vga_fb_arbiter. A behavioural model keeps
//            the raster as a linear pixel index and the arbiter as plain flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

  localparam int DIV   = 4;
  localparam int GUARD = 8;
  localparam int H_TOT = 800;
  localparam int V_TOT = 525;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        en      = 1'b0;
  logic        wr_req  = 1'b0;
  logic        wr_done = 1'b0;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        pix_tick;
  logic        frame_start;
  logic        disp_own;
  logic        wr_grant;
  logic        wr_abort;
`ifdef VGA_ARB_STATS_EN
  logic [15:0] abort_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  int m_phase;
  int m_pos;
  int m_aborts;
  bit m_grant;
  bit m_cool;
  bit m_abort;

  logic [24:0] dut_vec;
  assign dut_vec = {h_count, v_count, pix_tick, frame_start, disp_own, wr_grant, wr_abort};

  vga_fb_arbiter #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .h_count     (h_count),
    .v_count     (v_count),
    .pix_tick    (pix_tick),
    .frame_start (frame_start),
    .disp_own    (disp_own),
    .wr_req      (wr_req),
    .wr_done     (wr_done),
    .wr_grant    (wr_grant),
    .wr_abort    (wr_abort)
`ifdef VGA_ARB_STATS_EN
    ,
    .abort_cnt   (abort_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Writer may hold the buffer at raster index pos
  function automatic bit win_at(int pos);
    int h;
    int v;
    h = pos % H_TOT;
    v = pos / H_TOT;
    return (h >= 640 || v >= 480) && !((h >= H_TOT - GUARD) && (v < 479 || v == V_TOT - 1));
  endfunction

  function automatic logic [24:0] exp_vec();
    int h;
    int v;
    bit pix;
    h   = m_pos % H_TOT;
    v   = m_pos / H_TOT;
    pix = en && (m_phase == DIV - 1);
    return {10'(h), 10'(v), pix, pix && (m_pos == FRAME - 1),
            (h < 640 && v < 480), m_grant, m_abort && en};
  endfunction

  function automatic void model_reset();
    m_phase  = 0;
    m_pos    = 0;
    m_aborts = 0;
    m_grant  = 0;
    m_cool   = 0;
    m_abort  = 0;
  endfunction

  // One system clock of the reference model, given the inputs at that edge
  function automatic void model_step(bit e, bit rq, bit dn);
    bit w;
    if (e && m_abort && m_aborts < 65535) m_aborts++;
    if (!e) begin
      m_abort = 0;
      return;
    end
    w = win_at(m_pos);
    if (m_grant) begin
      m_grant = 0;
      m_cool  = 1;
      m_abort = !dn && !w;
      if (dn || !w) begin
        // released
      end else begin
        m_grant = 1;
        m_cool  = 0;
      end
    end else if (m_cool) begin
      m_cool  = 0;
      m_abort = 0;
    end else begin
      m_abort = 0;
      if (rq && w) m_grant = 1;
    end
    if (m_phase == DIV - 1) begin
      m_phase = 0;
      m_pos   = (m_pos + 1) % FRAME;
    end else begin
      m_phase++;
    end
  endfunction

  task automatic tick();
    bit e;
    bit rq;
    bit dn;
    e  = en;
    rq = wr_req;
    dn = wr_done;
    @(posedge clk);
    model_step(e, rq, dn);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    en      = 1'b1;
    wr_req  = 1'b0;
    wr_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_reset();
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== {20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: actual=%h required=%h", dut_vec, {20'd0, 5'b00100});
    end
`ifdef VGA_ARB_STATS_EN
    checks++;
    if (abort_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_abort_cnt: actual=%0d required=0", abort_cnt);
    end
`endif
    reset_n = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_pix_tick();
    int pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pix_tick === 1'b1) pulses++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL pix_tick_vec cyc=%0d: actual=%h required=%h", cyc, dut_vec, exp_vec());
      end
    end
    checks++;
    if (pulses !== 40 / DIV) begin
      errors++;
      $display("FAIL pix_tick_count: actual=%0d required=%0d", pulses, 40 / DIV);
    end
  endtask

  task automatic test_req_from_reset();
    bit got = 0;
    do_reset();
    wr_req = 1'b1;
    for (int i = 0; i < 5000 && !got; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL req_wait_vec cyc=%0d: actual=%h required=%h", cyc, dut_vec, exp_vec());
      end
      if (wr_grant === 1'b1) got = 1;
    end
    checks++;
    if (!got || cyc != 640 * DIV + 1 || h_count !== 10'd640 || v_count !== 10'd0) begin
      errors++;
      $display("FAIL first_grant: actual=cyc%0d h%0d v%0d required=cyc%0d h640 v0",
               cyc, h_count, v_count, 640 * DIV + 1);
    end
  endtask

  task automatic test_abort();
    bit got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL abort_wait_vec cyc=%0d: actual=%h required=%h", cyc, dut_vec, exp_vec());
      end
      if (wr_abort === 1'b1) got = 1;
    end
    checks++;
    if (!got || cyc != (H_TOT - GUARD) * DIV + 1 || h_count !== 10'(H_TOT - GUARD) || wr_grant !== 1'b0) begin
      errors++;
      $display("FAIL abort_point: actual=cyc%0d h%0d grant%b required=cyc%0d h%0d grant0",
               cyc, h_count, wr_grant, (H_TOT - GUARD) * DIV + 1, H_TOT - GUARD);
    end
    got = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL regrant_wait_vec cyc=%0d: actual=%h required=%h", cyc, dut_vec, exp_vec());
      end
      if (wr_grant === 1'b1) got = 1;
    end
    checks++;
    if (!got || cyc != (H_TOT + 640) * DIV + 1 || v_count !== 10'd1) begin
      errors++;
      $display("FAIL regrant_point: actual=cyc%0d v%0d required=cyc%0d v1",
               cyc, v_count, (H_TOT + 640) * DIV + 1);
    end
  endtask

  task automatic test_done_at_close();
    int aborts_before;
    aborts_before = m_aborts;
    for (int i = 0; i < 2000 && (m_pos % H_TOT) != H_TOT - GUARD; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL close_wait_vec cyc=%0d: actual=%h required=%h", cyc, dut_vec, exp_vec());
      end
    end
    checks++;
    if (wr_grant !== 1'b1 || h_count !== 10'(H_TOT - GUARD)) begin
      errors++;
      $display("FAIL close_pre_grant: actual=grant%b h%0d required=grant1 h%0d",
               wr_grant, h_count, H_TOT - GUARD);
    end
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_abort !== 1'b0 || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL done_wins: actual=%h required=%h", dut_vec, exp_vec());
      end
      tick();
    end
`ifdef VGA_ARB_STATS_EN
    checks++;
    if (abort_cnt !== 16'(aborts_before)) begin
      errors++;
      $display("FAIL done_wins_cnt: actual=%0d required=%0d", abort_cnt, aborts_before);
    end
`endif
  endtask

  task automatic test_done_random();
    for (int i = 0; i < 3 * H_TOT * DIV; i++) begin
      wr_req  = ($urandom_range(0, 9) != 0);
      wr_done = m_grant && ($urandom_range(0, 49) == 0);
      tick();
      wr_done = 1'b0;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL done_random_vec cyc=%0d: actual=%h required=%h", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_en_freeze();
    bit got = 0;
    logic [9:0] h_saved;
    logic [9:0] v_saved;
    wr_req = 1'b1;
    for (int i = 0; i < 8000 && !got; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL freeze_wait_vec cyc=%0d: actual=%h required=%h", cyc, dut_vec, exp_vec());
      end
      if (wr_grant === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL freeze_grant: actual=no_grant required=grant");
    end
    h_saved = 10'(m_pos % H_TOT);
    v_saved = 10'(m_pos / H_TOT);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_req = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (dut_vec !== exp_vec() || h_count !== h_saved || v_count !== v_saved) begin
        errors++;
        $display("FAIL en_low_hold: actual=%h required=%h", dut_vec, exp_vec());
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (wr_grant !== 1'b0 || h_count !== 10'd0 || v_count !== 10'd0 || wr_abort !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: actual=grant%b h%0d v%0d abort%b required=grant0 h0 v0 abort0",
               wr_grant, h_count, v_count, wr_abort);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    en      = 1'b1;
    wr_req  = 1'b0;
    cyc     = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 6 * H_TOT * DIV; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      wr_req  = ($urandom_range(0, 3) != 0);
      wr_done = m_grant && ($urandom_range(0, 99) == 0);
      tick();
      wr_done = 1'b0;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random_vec cyc=%0d: actual=%h required=%h", cyc, dut_vec, exp_vec());
      end
`ifdef VGA_ARB_STATS_EN
      checks++;
      if (abort_cnt !== 16'(m_aborts)) begin
        errors++;
        $display("FAIL random_abort_cnt: actual=%0d required=%0d", abort_cnt, m_aborts);
      end
`endif
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pix_tick();
    test_req_from_reset();
    test_abort();
    test_done_at_close();
    test_done_random();
    test_en_freeze();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
